// File: rtl/alu_pkg.sv
// Shared ALU definitions.
// Widths and FSM encoding for the multi-cycle ALU path.
package alu_pkg;

  localparam int WIDTH8 = 8;
  localparam int CNT_W  = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell.
// Purely combinational; outputs listed first.
module full_subtractor (
  output logic diff,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  // Difference and borrow-out of a - b - bin
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor8.sv
// Bit-serial 8-bit subtractor, LSB first.
// One full-subtractor cell plus a registered borrow.
module serial_subtractor8
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrowout,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PRE  = CNT_W'(WIDTH - 2);

  sub_state_t       state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [CNT_W-1:0] cnt_q;
  logic             brw_q, bin7_q;
  logic [WIDTH-1:0] diff_q;
  logic             bo_q, ovf_q;
  logic             d_bit, b_out;
  logic [WIDTH-1:0] res_d;

  full_subtractor u_fs (
    .diff (d_bit),
    .bout (b_out),
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (brw_q)
  );

  assign res_d = {d_bit, res_q[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (cnt_q == LAST) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand/result shifting, borrow chain and result capture.
  // Results load on the last RUN edge so they are valid in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      res_q  <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      bin7_q <= 1'b0;
      diff_q <= '0;
      bo_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        a_q   <= a;
        b_q   <= b;
        brw_q <= 1'b0;
        cnt_q <= '0;
      end else if (state_q == RUN) begin
        a_q   <= a_q >> 1;
        b_q   <= b_q >> 1;
        res_q <= res_d;
        brw_q <= b_out;
        cnt_q <= cnt_q + 1'b1;
        if (cnt_q == PRE) bin7_q <= b_out;
        if (cnt_q == LAST) begin
          diff_q <= res_d;
          bo_q   <= b_out;
          ovf_q  <= bin7_q ^ b_out;
        end
      end
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign diff      = diff_q;
  assign borrowout = bo_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor8.sv
// Directed and random checks for serial_subtractor8.
module tb_serial_subtractor8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic       busy, done, borrowout, overflow;
  logic [7:0] diff;

  int checks = 0;
  int errors = 0;
  logic [7:0] prev_diff = '0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_subtractor8 dut (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .busy(busy), .done(done),
    .diff(diff), .borrowout(borrowout),
    .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Run one op; pulse_at>0 injects a stray start in that RUN cycle.
  task automatic run_op(logic [7:0] av, logic [7:0] bv,
                        logic [7:0] ed, logic eb, logic eo,
                        int pulse_at);
    int k;
    bit got;
    start = 1'b1; a = av; b = bv;
    tick();
    start = 1'b0;
    k = 1; got = 0;
    while (k < 20 && !got) begin
      if (done) begin
        got = 1;
      end else begin
        chk("busy_run", {7'd0, busy}, 8'd1);
        chk("diff_hold", diff, prev_diff);
        if (k == pulse_at) begin
          start = 1'b1; a = 8'hFF; b = 8'h00;
        end else begin
          start = 1'b0;
        end
        tick();
        k++;
      end
    end
    start = 1'b0;
    chk("latency", 8'(k), 8'd9);
    chk("busy_in_done", {7'd0, busy}, 8'd0);
    chk("diff", diff, ed);
    chk("borrow", {7'd0, borrowout}, {7'd0, eb});
    chk("ovf", {7'd0, overflow}, {7'd0, eo});
    prev_diff = ed;
    tick();
    chk("done_single", {7'd0, done}, 8'd0);
    chk("busy_after", {7'd0, busy}, 8'd0);
  endtask

  initial begin
    logic [7:0] ra, rb, ed;
    logic eb, eo;
    int last_done, n;
    bit got;

    tick(); tick();
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_diff", diff, 8'd0);
    chk("rst_bo", {7'd0, borrowout}, 8'd0);
    chk("rst_ovf", {7'd0, overflow}, 8'd0);
    // Reset wins over start
    start = 1'b1; a = 8'h22; b = 8'h11;
    tick();
    chk("rst_prio", {7'd0, busy}, 8'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();

    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0);
    run_op(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 0);
    run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0);
    run_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0);
    run_op(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 3);

    // Reset in RUN cycle 4
    start = 1'b1; a = 8'h10; b = 8'h01;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    chk("pre_rst_busy", {7'd0, busy}, 8'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_diff", diff, 8'd0);
    chk("abort_bo", {7'd0, borrowout}, 8'd0);
    chk("abort_ovf", {7'd0, overflow}, 8'd0);
    got = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) got = 1;
      tick();
    end
    chk("abort_nodone", {7'd0, got}, 8'd0);
    prev_diff = 8'h00;
    run_op(8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 0);
    run_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 0);

    // Random back-to-back with start held high
    last_done = 0;
    ra = 8'($urandom); rb = 8'($urandom);
    a = ra; b = rb; start = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      n = 0;
      while (!done && n < 30) begin
        tick();
        n++;
      end
      checks++;
      assert (done === 1'b1) else begin
        errors++;
        $error("FAIL rnd_timeout observed=%0d expected=done", n);
      end
      if (!done) break;
      ed = ra - rb;
      eb = (ra < rb);
      eo = (ra[7] != rb[7]) && (ed[7] != ra[7]);
      chk("rnd_diff", diff, ed);
      chk("rnd_bo", {7'd0, borrowout}, {7'd0, eb});
      chk("rnd_ovf", {7'd0, overflow}, {7'd0, eo});
      if (i > 0) chk("rnd_space", 8'(cyc - last_done), 8'd10);
      last_done = cyc;
      ra = 8'($urandom); rb = 8'($urandom);
      a = ra; b = rb;
      tick();
    end
    start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
